// File: rtl/counter_cmd_gen_pkg.sv
// -----------------------------------------------------------------------------
// counter_cmd_pkg
//   Shared types and constants for the counter command generator.
//   - db_state_t : per-button debouncer state
//   - CMD_*      : command indices, listed highest priority first
//   - cnt_width  : width of the debounce/repeat counter
// -----------------------------------------------------------------------------
package counter_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REL_WAIT
    } db_state_t;

    // Command indices into the event vector; a lower index wins arbitration.
    localparam int CMD_LOAD = 0;
    localparam int CMD_DOWN = 1;
    localparam int CMD_UP   = 2;
    localparam int CMD_NUM  = 3;

    // One counter serves both debounce and repeat timing, so it must hold the
    // largest terminal value of the three.
    function automatic int cnt_width(input int db_cycles, input int rep_delay,
                                     input int rep_period);
        int m;
        m = db_cycles;
        if (rep_delay > m)  m = rep_delay;
        if (rep_period > m) m = rep_period;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/counter_cmd_gen_if.sv
// -----------------------------------------------------------------------------
// counter_cmd_gen_if
//   Command bus between the command generator (master) and the 5-bit
//   up/down counter (slave).
//   Load/Up/Down : one-cycle command pulses      (master -> slave)
//   IN           : load value, valid with Load   (master -> slave)
//   High/Low     : counter at max / at zero      (slave -> master)
// -----------------------------------------------------------------------------
interface counter_cmd_gen_if #(
    parameter int WIDTH = 5
);
    logic             Load;
    logic             Up;
    logic             Down;
    logic [WIDTH-1:0] IN;
    logic             High;
    logic             Low;

    modport master (output Load, Up, Down, IN, input High, Low);
    modport slave  (input Load, Up, Down, IN, output High, Low);
endinterface

// File: rtl/counter_cmd_gen_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   One push-button: 2-flop synchroniser, debounce FSM and, when the build
//   defines AUTO_REPEAT_EN, a hold-to-repeat timer.
//   CLK       in  clock, posedge
//   RST       in  synchronous active-high reset
//   btn       in  raw asynchronous button, active-high
//   press_evt out registered one-cycle pulse per accepted press (and per
//                 auto-repeat when enabled)
//   Optional feature macro: AUTO_REPEAT_EN (adds parameter REPEAT).
// -----------------------------------------------------------------------------
module btn_debounce
    import counter_cmd_pkg::*;
#(
    parameter int DB_CYCLES  = 16,
    parameter int REP_DELAY  = 64,
    parameter int REP_PERIOD = 16
`ifdef AUTO_REPEAT_EN
    ,
    parameter bit REPEAT     = 1'b0
`endif
) (
    input  logic CLK,
    input  logic RST,
    input  logic btn,
    output logic press_evt
);

    localparam int                CNT_W = cnt_width(DB_CYCLES, REP_DELAY, REP_PERIOD);
    localparam logic [CNT_W-1:0]  DB_T  = CNT_W'(DB_CYCLES);
    localparam logic [CNT_W-1:0]  ONE   = CNT_W'(1);
`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0]  REP_DELAY_T  = CNT_W'(REP_DELAY);
    localparam logic [CNT_W-1:0]  REP_PERIOD_T = CNT_W'(REP_PERIOD);
    logic                         rep_armed;   // first repeat already issued
`endif

    logic             sync1;
    logic             s;
    db_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    // Saturating increment: the counter never wraps back to a small value.
    assign cnt_inc = (cnt == '1) ? cnt : cnt + ONE;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side below reads the pre-edge value of the flops.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: the synchroniser is reset too, so a button held through
            // reset is seen as a fresh press starting from IDLE.
            sync1     <= 1'b0;
            s         <= 1'b0;
            state     <= IDLE;
            cnt       <= '0;
            press_evt <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rep_armed <= 1'b0;
`endif
        end else begin
            sync1     <= btn;
            s         <= sync1;
            press_evt <= 1'b0;
            case (state)
                IDLE: begin
                    if (s) begin
                        state <= PRESS_WAIT;
                        cnt   <= ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt_inc == DB_T) begin
                        state     <= HELD;
                        cnt       <= '0;
                        press_evt <= 1'b1;
`ifdef AUTO_REPEAT_EN
                        rep_armed <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                HELD: begin
                    if (!s) begin
                        state <= REL_WAIT;
                        cnt   <= ONE;
                    end
`ifdef AUTO_REPEAT_EN
                    // In HELD the counter times the gap to the next repeat:
                    // REP_DELAY for the first, REP_PERIOD thereafter.
                    else if (REPEAT) begin
                        if (cnt_inc == (rep_armed ? REP_PERIOD_T : REP_DELAY_T)) begin
                            press_evt <= 1'b1;
                            cnt       <= '0;
                            rep_armed <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
`endif
                end
                REL_WAIT: begin
                    if (s) begin
                        // Release bounce: back to HELD without a new event,
                        // and the repeat schedule starts over.
                        state <= HELD;
                        cnt   <= '0;
`ifdef AUTO_REPEAT_EN
                        rep_armed <= 1'b0;
`endif
                    end else if (cnt_inc == DB_T) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/counter_cmd_gen.sv
// -----------------------------------------------------------------------------
// counter_cmd_gen
//   Command stage for the 5-bit up/down counter. Debounces three raw buttons,
//   arbitrates simultaneous presses (Load > Down > Up), drops Up at High and
//   Down at Low, and registers the load value.
//   CLK       in  clock, posedge
//   RST       in  synchronous active-high reset
//   Btn_Up    in  raw up button
//   Btn_Dn    in  raw down button
//   Btn_Load  in  raw load button
//   Sw        in  load-value switches (WIDTH)
//   bus       counter_cmd_gen_if.master: Load/Up/Down/IN out, High/Low in
//   Optional feature macro: AUTO_REPEAT_EN (hold-to-repeat on Up and Down).
// -----------------------------------------------------------------------------
module counter_cmd_gen
    import counter_cmd_pkg::*;
#(
    parameter int WIDTH      = 5,
    parameter int DB_CYCLES  = 16,
    parameter int REP_DELAY  = 64,
    parameter int REP_PERIOD = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                Btn_Up,
    input  logic                Btn_Dn,
    input  logic                Btn_Load,
    input  logic [WIDTH-1:0]    Sw,
    counter_cmd_gen_if.master   bus
);

    logic [CMD_NUM-1:0] evt;
    logic               load_q;
    logic               up_q;
    logic               down_q;
    logic [WIDTH-1:0]   in_q;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .REP_DELAY (REP_DELAY),
        .REP_PERIOD(REP_PERIOD)
`ifdef AUTO_REPEAT_EN
        ,
        .REPEAT    (1'b0)
`endif
    ) u_db_load (
        .CLK      (CLK),
        .RST      (RST),
        .btn      (Btn_Load),
        .press_evt(evt[CMD_LOAD])
    );

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .REP_DELAY (REP_DELAY),
        .REP_PERIOD(REP_PERIOD)
`ifdef AUTO_REPEAT_EN
        ,
        .REPEAT    (1'b1)
`endif
    ) u_db_down (
        .CLK      (CLK),
        .RST      (RST),
        .btn      (Btn_Dn),
        .press_evt(evt[CMD_DOWN])
    );

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .REP_DELAY (REP_DELAY),
        .REP_PERIOD(REP_PERIOD)
`ifdef AUTO_REPEAT_EN
        ,
        .REPEAT    (1'b1)
`endif
    ) u_db_up (
        .CLK      (CLK),
        .RST      (RST),
        .btn      (Btn_Up),
        .press_evt(evt[CMD_UP])
    );

    // Arbitrate first, then filter: a losing event is gone even if the
    // winner is itself dropped by the saturation filter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            load_q <= 1'b0;
            up_q   <= 1'b0;
            down_q <= 1'b0;
            in_q   <= '0;
        end else begin
            load_q <= 1'b0;
            up_q   <= 1'b0;
            down_q <= 1'b0;
            if (evt[CMD_LOAD]) begin
                load_q <= 1'b1;
                in_q   <= Sw;
            end else if (evt[CMD_DOWN]) begin
                down_q <= !bus.Low;
            end else if (evt[CMD_UP]) begin
                up_q   <= !bus.High;
            end
        end
    end

    assign bus.Load = load_q;
    assign bus.Up   = up_q;
    assign bus.Down = down_q;
    assign bus.IN   = in_q;

endmodule

// File: tb/tb_counter_cmd_gen.sv
// -----------------------------------------------------------------------------
// tb_counter_cmd_gen
//   Self-checking bench for counter_cmd_gen. A behavioural model (stable-run
//   counting per button, hold-time counting for repeats) predicts every output
//   every cycle; table rows and directed sequences check counts and latency.
// -----------------------------------------------------------------------------
module tb_counter_cmd_gen;

    localparam int WIDTH = 5;
    localparam int DB    = 16;
    localparam int RD    = 64;
    localparam int RP    = 16;

    logic             CLK = 1'b0;
    logic             RST;
    logic             Btn_Up;
    logic             Btn_Dn;
    logic             Btn_Load;
    logic [WIDTH-1:0] Sw;

    counter_cmd_gen_if #(.WIDTH(WIDTH)) bus ();

    counter_cmd_gen #(
        .WIDTH     (WIDTH),
        .DB_CYCLES (DB),
        .REP_DELAY (RD),
        .REP_PERIOD(RP)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .Btn_Up  (Btn_Up),
        .Btn_Dn  (Btn_Dn),
        .Btn_Load(Btn_Load),
        .Sw      (Sw),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (index 0=load, 1=down, 2=up) ---------
    logic             m_s1 [3];
    logic             m_s2 [3];
    logic             m_lvl[3];
    int               m_run[3];
    int               m_held[3];
    logic             m_pend[3];
    logic             e_load, e_up, e_down;
    logic [WIDTH-1:0] e_in;

    function automatic bit rep_en(input int b);
`ifdef AUTO_REPEAT_EN
        return b != 0;
`else
        return (b < 0);
`endif
    endfunction

    task automatic model_edge();
        logic raw[3];
        logic nxt[3];
        raw = '{Btn_Load, Btn_Dn, Btn_Up};
        if (RST) begin
            for (int b = 0; b < 3; b++) begin
                m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0;
                m_run[b] = 0; m_held[b] = 0; m_pend[b] = 0;
            end
            e_load = 0; e_up = 0; e_down = 0; e_in = '0;
        end else begin
            e_load = 0; e_up = 0; e_down = 0;
            if (m_pend[0]) begin
                e_load = 1; e_in = Sw;
            end else if (m_pend[1]) e_down = !bus.Low;
            else if (m_pend[2])     e_up   = !bus.High;
            for (int b = 0; b < 3; b++) begin
                nxt[b] = 0;
                if (m_s2[b] != m_lvl[b]) begin
                    // synced value differs from the accepted level
                    m_held[b] = 0;
                    m_run[b]++;
                    if (m_run[b] == DB) begin
                        m_lvl[b] = m_s2[b];
                        m_run[b] = 0;
                        nxt[b]   = m_s2[b];
                    end
                end else if (m_run[b] != 0) begin
                    m_run[b]  = 0;
                    m_held[b] = 0;
                end else if (m_lvl[b] && rep_en(b)) begin
                    m_held[b]++;
                    if (m_held[b] == RD || (m_held[b] > RD && (m_held[b] - RD) % RP == 0))
                        nxt[b] = 1;
                end
            end
            for (int b = 0; b < 3; b++) begin
                m_pend[b] = nxt[b];
                m_s2[b]   = m_s1[b];
                m_s1[b]   = raw[b];
            end
        end
    endtask

    // One clock: model on the edge, compare at the following negedge.
    task automatic step();
        @(posedge CLK);
        cyc++;
        model_edge();
        @(negedge CLK);
        check("Load", bus.Load, e_load);
        check("Up",   bus.Up,   e_up);
        check("Down", bus.Down, e_down);
        check("IN",   bus.IN,   e_in);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // ---------------- table vectors ----------------------------------------
    typedef struct {
        logic             up, dn, ld;
        logic [WIDTH-1:0] sw;
        logic             high, low;
        int               n_load, n_up, n_down;
        logic [WIDTH-1:0] in_after;
    } vec_t;

    vec_t vecs[9];

    int n_ld, n_up, n_dn, first, t0, r, a;
    int offs[$];
    int exp_offs[$];
    int hold[3];
    logic lv[3];

    initial begin
        RST = 1; Btn_Up = 0; Btn_Dn = 0; Btn_Load = 0; Sw = '0;
        bus.High = 0; bus.Low = 0;

        //            up dn ld  sw    hi lo  ld up dn  in
        vecs[0] = '{1, 0, 0, 5'd3,  0, 0, 0, 1, 0, 5'd0};
        vecs[1] = '{1, 0, 0, 5'd3,  1, 0, 0, 0, 0, 5'd0};
        vecs[2] = '{0, 1, 0, 5'd9,  0, 0, 0, 0, 1, 5'd0};
        vecs[3] = '{0, 1, 0, 5'd9,  0, 1, 0, 0, 0, 5'd0};
        vecs[4] = '{1, 0, 1, 5'd19, 0, 0, 1, 0, 0, 5'd19};
        vecs[5] = '{1, 1, 0, 5'd2,  0, 0, 0, 0, 1, 5'd19};
        vecs[6] = '{1, 1, 0, 5'd2,  0, 1, 0, 0, 0, 5'd19};
        vecs[7] = '{0, 0, 1, 5'd7,  1, 1, 1, 0, 0, 5'd7};
        vecs[8] = '{1, 1, 1, 5'd31, 0, 0, 1, 0, 0, 5'd31};

        // Reset: outputs must be zero (compared inside step)
        idle(3);
        RST = 0;
        idle(5);

        for (int i = 0; i < 9; i++) begin
            n_ld = 0; n_up = 0; n_dn = 0;
            Sw = vecs[i].sw; bus.High = vecs[i].high; bus.Low = vecs[i].low;
            Btn_Up = vecs[i].up; Btn_Dn = vecs[i].dn; Btn_Load = vecs[i].ld;
            for (int c = 0; c < 2 * (DB + 10); c++) begin
                if (c == DB + 10) begin
                    Btn_Up = 0; Btn_Dn = 0; Btn_Load = 0;
                end
                step();
                n_ld += int'(bus.Load); n_up += int'(bus.Up); n_dn += int'(bus.Down);
            end
            check($sformatf("vec%0d load count", i), n_ld, vecs[i].n_load);
            check($sformatf("vec%0d up count", i),   n_up, vecs[i].n_up);
            check($sformatf("vec%0d down count", i), n_dn, vecs[i].n_down);
            check($sformatf("vec%0d IN", i),         bus.IN, vecs[i].in_after);
        end
        bus.High = 0; bus.Low = 0;

        // Latency: first sampled at edge t0 -> pulse registered on edge t0+2+DB
        n_up = 0; n_ld = 0; n_dn = 0; first = -1;
        Btn_Up = 1; t0 = cyc + 1;
        for (int c = 0; c < 40; c++) begin
            step();
            if (bus.Up) begin n_up++; if (first < 0) first = cyc; end
            n_ld += int'(bus.Load); n_dn += int'(bus.Down);
        end
        check("latency up edge", first, t0 + 2 + DB);
        check("latency up count", n_up, 1);
        check("latency no load/down", n_ld + n_dn, 0);
        Btn_Up = 0; idle(30);

        // Bounce every 5 cycles: nothing; then stable hold: one Down
        n_dn = 0;
        for (int c = 0; c < 60; c++) begin
            Btn_Dn = ((c / 5) % 2 == 0);
            step();
            n_dn += int'(bus.Down);
        end
        check("bounce down count", n_dn, 0);
        n_dn = 0; Btn_Dn = 1;
        for (int c = 0; c < 20; c++) begin
            step();
            n_dn += int'(bus.Down);
        end
        check("bounce then hold down count", n_dn, 1);
        Btn_Dn = 0; idle(30);

        // Reset mid PRESS_WAIT, button kept high
        Btn_Up = 1; idle(8);
        RST = 1; n_up = 0;
        for (int c = 0; c < 3; c++) begin
            step(); n_up += int'(bus.Up);
        end
        check("pulses during reset", n_up, 0);
        r = cyc; RST = 0; first = -1; n_up = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (bus.Up) begin n_up++; if (first < 0) first = cyc; end
        end
        check("post-reset pulse edge", first, r + DB + 3);
        check("post-reset pulse count", n_up, 1);
        Btn_Up = 0; idle(30);

        // Long hold: auto-repeat schedule relative to the first pulse
        Btn_Up = 1; a = -1;
        for (int c = 0; c < 30 && a < 0; c++) begin
            step();
            if (bus.Up) a = cyc;
        end
        check("hold first pulse seen", (a >= 0), 1);
        offs.delete();
        for (int c = 0; c < 150; c++) begin
            step();
            if (bus.Up) offs.push_back(cyc - a);
        end
        exp_offs.delete();
`ifdef AUTO_REPEAT_EN
        for (int o = RD; o <= 150; o += RP) exp_offs.push_back(o);
`endif
        check("repeat count", offs.size(), exp_offs.size());
        for (int i = 0; i < exp_offs.size() && i < offs.size(); i++)
            check($sformatf("repeat offset %0d", i), offs[i], exp_offs[i]);
        Btn_Up = 0; idle(30);

        // Randomised stimulus against the model
        for (int b = 0; b < 3; b++) begin hold[b] = 0; lv[b] = 0; end
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (hold[b] == 0) begin
                    lv[b]   = !lv[b];
                    hold[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                                          : int'($urandom_range(5, 45));
                end else begin
                    hold[b]--;
                end
            end
            Btn_Load = lv[0]; Btn_Dn = lv[1]; Btn_Up = lv[2];
            if ($urandom_range(0, 7) == 0) bus.High = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) bus.Low  = 1'($urandom_range(0, 1));
            Sw  = WIDTH'($urandom);
            RST = ($urandom_range(0, 599) == 0);
            step();
        end
        RST = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
